udp_tx_serializer: RTL

UDP_TX_SERIALIZER -- requirements
Module: udp_tx_serializer

---
 rtl/udp_tx_pkg.sv | 33 +++
 rtl/udp_tx_keep_scan.sv | 34 +++
 rtl/udp_tx_serializer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/udp_tx_pkg.sv
// -----------------------------------------------------------------------------
// udp_tx_pkg
// Shared types and constants for the UDP TX word-to-byte serializer.
//   state_t        : serializer FSM state (IDLE / ACTIVE)
//   LEN_W_DEFAULT  : default width of length input, byte counter and count out
//   LANE_0..LANE_3 : byte-lane indices inside a 32-bit word (LANE_3 = [31:24])
//   lane_byte()    : extracts one byte lane from a word
//   lane_bit()     : one-hot mask for a lane index
// -----------------------------------------------------------------------------
package udp_tx_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int LEN_W_DEFAULT = 16;

  localparam logic [1:0] LANE_0 = 2'd0;  // [7:0],   goes out last
  localparam logic [1:0] LANE_1 = 2'd1;  // [15:8]
  localparam logic [1:0] LANE_2 = 2'd2;  // [23:16]
  localparam logic [1:0] LANE_3 = 2'd3;  // [31:24], goes out first

  function automatic logic [7:0] lane_byte(input logic [31:0] word,
                                           input logic [1:0]  lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

  function automatic logic [3:0] lane_bit(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/udp_tx_keep_scan.sv
// -----------------------------------------------------------------------------
// udp_tx_keep_scan
// Combinational next-kept-lane finder. Given the mask of lanes still to be
// sent, returns the most significant set lane (the next byte to emit), the
// mask left after that lane is removed, and whether that lane is the last one.
// Ports:
//   mask_i [3:0] : remaining-lane mask (bit 3 = [31:24])
//   lane_o [1:0] : index of the next lane to emit (LANE_0 when mask is empty)
//   last_o       : no other lane remains after lane_o
//   rem_o  [3:0] : mask_i with lane_o cleared
// -----------------------------------------------------------------------------
module udp_tx_keep_scan
  import udp_tx_pkg::*;
(
  input  logic [3:0] mask_i,
  output logic [1:0] lane_o,
  output logic       last_o,
  output logic [3:0] rem_o
);

  always_comb begin
    lane_o = LANE_0;
    if (mask_i[3]) begin
      lane_o = LANE_3;
    end else if (mask_i[2]) begin
      lane_o = LANE_2;
    end else if (mask_i[1]) begin
      lane_o = LANE_1;
    end
    rem_o  = mask_i & ~lane_bit(lane_o);
    last_o = (rem_o == 4'b0000);
  end

endmodule

// File: rtl/udp_tx_serializer.sv
// -----------------------------------------------------------------------------
// udp_tx_serializer
// Serializes 32-bit AXI-Stream beats into 8-bit AXI-Stream bytes, MSB lane
// first, dropping lanes whose tkeep bit is clear. Counts emitted bytes per
// packet and pulses pkt_done at packet end.
//
// Optional feature: define UDP_TX_LEN_CHECK_EN to latch s_length_in (byte
// count minus 1) on tfirst and pulse len_err on a length mismatch, an empty
// tlast beat, or a tfirst arriving inside an open packet. Without the macro
// len_err is tied low and no length logic exists.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   s_axis_tdata/tkeep    : input word and byte enables (tkeep[3] = [31:24])
//   s_axis_tvalid/tready  : input handshake
//   s_axis_tfirst/tlast   : packet start / end markers on the input beat
//   s_length_in           : packet length minus 1, sampled on tfirst beats
//   m_axis_tdata/tvalid/tlast/tready : byte output stream
//   byte_count_out        : bytes emitted in the current or last packet
//   pkt_done              : one-cycle pulse at packet end
//   len_err               : one-cycle length/format error pulse
// -----------------------------------------------------------------------------
module udp_tx_serializer
  import udp_tx_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      s_axis_tdata,
  input  logic [3:0]       s_axis_tkeep,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tfirst,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  input  logic [LEN_W-1:0] s_length_in,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic [LEN_W-1:0] byte_count_out,
  output logic             pkt_done,
  output logic             len_err
);

  state_t           state_q;
  logic [31:0]      word_q;       // loaded word, kept until its last byte leaves
  logic [3:0]       rem_q;        // lanes still to present after the current byte
  logic             beat_last_q;  // loaded word carried s_axis_tlast
  logic [7:0]       m_tdata_q;
  logic             m_tvalid_q;
  logic             m_tlast_q;
  logic [LEN_W-1:0] cnt_q;
  logic             pkt_done_q;

  logic             m_hs;
  logic             s_hs;
  logic             word_done;
  logic             keep_zero;
  logic             load;
  logic             present;
  logic [3:0]       scan_mask;
  logic [3:0]       scan_rem;
  logic [1:0]       scan_lane;
  logic             scan_last;
  logic [31:0]      src_word;
  logic             src_last;
  logic [LEN_W-1:0] cnt_inc;

  assign m_hs      = m_tvalid_q & m_axis_tready;
  // Last kept byte of the loaded word leaves this cycle.
  assign word_done = (state_q == ACTIVE) & m_hs & (rem_q == 4'b0000);
  // Gated by reset so tready stays low for the whole reset period.
  assign s_axis_tready = ~reset & ((state_q == IDLE) | word_done);
  assign s_hs      = s_axis_tvalid & s_axis_tready;
  assign keep_zero = (s_axis_tkeep == 4'b0000);
  assign load      = s_hs & ~keep_zero;
  // A new byte is placed on m_axis either from a freshly accepted word or
  // from the next pending lane of the current one. Both never coincide:
  // loading in ACTIVE requires rem_q to be empty.
  assign present   = load | ((state_q == ACTIVE) & m_hs & (rem_q != 4'b0000));

  // One scanner serves both cases since load and advance are exclusive.
  assign scan_mask = load ? s_axis_tkeep : rem_q;
  assign src_word  = load ? s_axis_tdata : word_q;
  assign src_last  = load ? s_axis_tlast : beat_last_q;

  udp_tx_keep_scan u_keep_scan (
    .mask_i (scan_mask),
    .lane_o (scan_lane),
    .last_o (scan_last),
    .rem_o  (scan_rem)
  );

  assign cnt_inc = (cnt_q == {LEN_W{1'b1}}) ? cnt_q
                                            : cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      word_q      <= '0;
      rem_q       <= '0;
      beat_last_q <= 1'b0;
      m_tdata_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      cnt_q       <= '0;
      pkt_done_q  <= 1'b0;
    end else begin
      pkt_done_q <= (m_hs & m_tlast_q) | (s_hs & keep_zero & s_axis_tlast);

      // A tfirst clear wins over a concurrent handshake of the previous
      // word's last byte, which belongs to the old packet.
      if (s_hs & s_axis_tfirst) begin
        cnt_q <= '0;
      end else if (m_hs) begin
        cnt_q <= cnt_inc;
      end

      if (present) begin
        state_q    <= ACTIVE;
        m_tdata_q  <= lane_byte(src_word, scan_lane);
        m_tvalid_q <= 1'b1;
        m_tlast_q  <= src_last & scan_last;
        rem_q      <= scan_rem;
      end else if (word_done) begin
        state_q    <= IDLE;
        m_tvalid_q <= 1'b0;
        m_tlast_q  <= 1'b0;
      end

      if (load) begin
        word_q      <= s_axis_tdata;
        beat_last_q <= s_axis_tlast;
      end
    end
  end

  assign m_axis_tdata   = m_tdata_q;
  assign m_axis_tvalid  = m_tvalid_q;
  assign m_axis_tlast   = m_tlast_q;
  assign byte_count_out = cnt_q;
  assign pkt_done       = pkt_done_q;

`ifdef UDP_TX_LEN_CHECK_EN
  logic [LEN_W-1:0] len_q;
  logic             open_q;     // tfirst seen, tlast not yet
  logic             len_err_q;
  logic             len_mismatch;

  // Uses the count including the byte leaving this cycle; compared one bit
  // wider so len_q = all-ones does not wrap.
  assign len_mismatch = ({1'b0, cnt_inc} != ({1'b0, len_q} + {{LEN_W{1'b0}}, 1'b1}));

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q     <= '0;
      open_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= (m_hs & m_tlast_q & len_mismatch)
                 | (s_hs & keep_zero & s_axis_tlast)
                 | (s_hs & s_axis_tfirst & open_q);
      if (s_hs & s_axis_tfirst) begin
        len_q <= s_length_in;
      end
      if (s_hs) begin
        open_q <= ~s_axis_tlast & (s_axis_tfirst | open_q);
      end
    end
  end

  assign len_err = len_err_q;
`else
  logic unused_len;
  assign unused_len = ^s_length_in;
  assign len_err    = 1'b0;
`endif

endmodule
